// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and port identifiers.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DMA  = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin selector: a lone requester wins; on a tie the port
// that was not granted most recently wins.
module rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic  i_req_core,
  input  logic  i_req_dma,
  input  port_e i_last,
  output logic  o_gnt_core,
  output logic  o_gnt_dma
);

  assign o_gnt_core = i_req_core & (~i_req_dma | (i_last == PORT_DMA));
  assign o_gnt_dma  = i_req_dma & ~o_gnt_core;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core and a DMA engine.
// Grants are combinational; DMA bursts lock the port until d_last or
// BURST_MAX beats, after which a waiting core request gets the next slot.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  // core port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_last,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory port
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int CW = $clog2(BURST_MAX + 1);

  state_e        r_state;
  state_e        w_nxt_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] w_cnt_inc;
  port_e         r_last;
  logic          r_rd_vld;
  port_e         r_rd_own;
  logic          w_rr_c;
  logic          w_rr_d;
  logic          w_c_gnt;
  logic          w_d_gnt;

  rr_pick u_rr (
    .i_req_core (c_req),
    .i_req_dma  (d_req),
    .i_last     (r_last),
    .o_gnt_core (w_rr_c),
    .o_gnt_dma  (w_rr_d)
  );

  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state and grant decode; nothing is granted while reset is low.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_c_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          w_c_gnt = w_rr_c;
          w_d_gnt = w_rr_d;
          if (w_rr_d && !d_last && (BURST_MAX > 1)) begin
            w_nxt_state = ST_BURST;
            w_nxt_cnt   = CW'(1);
          end
        end
        ST_BURST: begin
          // DMA owns the port; a stalled DMA beat keeps ownership and count.
          w_d_gnt = d_req;
          if (d_req) begin
            if (d_last || (w_cnt_inc == CW'(BURST_MAX))) begin
              w_nxt_state = ST_IDLE;
              w_nxt_cnt   = '0;
            end else begin
              w_nxt_cnt = w_cnt_inc;
            end
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Memory-side mux from the granted port; all zero when idle.
  always_comb begin
    m_en    = w_c_gnt | w_d_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (w_d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  // FSM, burst counter, round-robin history and read-return tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= PORT_DMA;
      r_rd_vld <= 1'b0;
      r_rd_own <= PORT_CORE;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      if (w_c_gnt)      r_last <= PORT_CORE;
      else if (w_d_gnt) r_last <= PORT_DMA;
      r_rd_vld <= m_en & ~m_we;
      r_rd_own <= w_d_gnt ? PORT_DMA : PORT_CORE;
    end
  end

  assign c_gnt    = w_c_gnt;
  assign d_gnt    = w_d_gnt;
  assign c_stall  = c_req & ~w_c_gnt;
  // Read returns are suppressed while reset is held so nothing leaks out.
  assign c_rvalid = reset & r_rd_vld & (r_rd_own == PORT_CORE);
  assign d_rvalid = reset & r_rd_vld & (r_rd_own == PORT_DMA);
  assign c_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data memory address width.
REQ-002 Parameter DW, default 8, data word width.
REQ-003 Parameter BURST_MAX, default 16, maximum consecutive DMA grants before forced release.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 c_req / c_we  in  1 / 1  core access request / write select.
REQ-007 c_addr / c_wdata  in  AW / DW  core address / store data.
REQ-008 c_gnt  out  1  core access accepted this cycle.
REQ-009 c_stall  out  1  c_req & ~c_gnt; holds PC and register writeback.
REQ-010 c_rvalid / c_rdata  out  1 / DW  core read data, one cycle after granted read.
REQ-011 d_req / d_we / d_last  in  1 / 1 / 1  DMA request / write select / final beat of burst.
REQ-012 d_addr / d_wdata  in  AW / DW  DMA address / store data.
REQ-013 d_gnt  out  1  DMA access accepted this cycle.
REQ-014 d_rvalid / d_rdata  out  1 / DW  DMA read data, one cycle after granted read.
REQ-015 m_en / m_we  out  1 / 1  memory access strobe / write enable.
REQ-016 m_addr / m_wdata  out  AW / DW  memory address / write data, from granted port.
REQ-017 m_rdata  in  DW  memory read data, valid one cycle after m_en & ~m_we.

Function
REQ-018 At most one grant per cycle; c_gnt & d_gnt never both 1.
REQ-019 Grants are combinational from current requests and registered state; a request is accepted in the cycle its gnt is 1.
REQ-020 m_en = c_gnt | d_gnt; m_we/m_addr/m_wdata mux from granted port; all 0 when no grant.
REQ-021 FSM states: IDLE, BURST.
REQ-022 IDLE, one requester: grant it.
REQ-023 IDLE, both requesting: grant the port not granted most recently (round-robin via last_gnt flag).
REQ-024 IDLE -> BURST when d_gnt & ~d_last; burst counter loads 1.
REQ-025 BURST: d_gnt = d_req, c_gnt = 0, even if c_req is 1.
REQ-026 BURST: each d_gnt increments counter; granted beat with d_last=1 -> IDLE.
REQ-027 BURST: counter reaching BURST_MAX on a granted beat -> IDLE; last_gnt = DMA so a pending core request wins the next cycle.
REQ-028 BURST with d_req=0 -> remain in BURST, no grant, counter held (DMA owns the port until d_last or BURST_MAX).
REQ-029 last_gnt updates on every grant to the granted port.
REQ-030 Read tag register: captures {valid, owner} on every granted read; c_rvalid/d_rvalid asserted the next cycle for the owner only; c_rdata = d_rdata = m_rdata.
REQ-031 Granted writes produce no rvalid.
REQ-032 Back-to-back granted reads from alternating ports yield one rvalid per cycle with correct owner.

Reset
REQ-033 While reset=0 at a clock edge: state IDLE, counter 0, last_gnt DMA, read tag valid 0.
REQ-034 During and after reset: c_gnt, d_gnt, m_en, m_we, c_rvalid, d_rvalid all 0 until a request is sampled after reset deasserts; a read granted in the cycle reset asserts produces no rvalid.
REQ-035 Reset mid-burst abandons the burst; no partial state survives.

Structure
REQ-036 Shared package holds the FSM state enum and the port-id enum (CORE, DMA).
REQ-037 One sub-module: rr_pick, a two-way round-robin selector used by IDLE.
REQ-038 Target size 120-400 lines of RTL, no memories inside the block.

Verification
REQ-039 After reset, c_req=1 read addr 0x10, m_rdata=0x5A -> c_gnt same cycle, c_rvalid=1 with c_rdata=0x5A next cycle, c_stall=0.
REQ-040 c_req and d_req both held from reset -> first grant CORE, then DMA, alternating each cycle.
REQ-041 DMA 4-beat write burst (d_last on beat 4) with c_req=1 throughout -> d_gnt 4 cycles, c_stall=1 those cycles, c_gnt on cycle 5.
REQ-042 DMA burst with d_last never set, BURST_MAX=16, c_req=1 -> exactly 16 d_gnt, then c_gnt next cycle.
REQ-043 Alternating CORE read / DMA read back-to-back -> rvalid pulses route to the correct owner every cycle, never both.
REQ-044 reset=0 asserted in cycle 3 of a burst -> next cycle IDLE, all outputs 0, no rvalid; subsequent c_req granted immediately.
